// File: rtl/sleep_scheduler_if.sv
// Signal bundle between sleep_scheduler and its stimulus/energy/regulator neighbours.
// master drives stimulus and observes results; slave is the scheduler itself.
interface sleep_scheduler_if;
  logic       tick;
  logic       tired;
  logic       disturb;
  logic [7:0] action;
  logic [1:0] vital_energy_level;
  logic       sleep_in_signal;
  logic       wake_up_signal;
  logic [1:0] sleep_state;
  logic [3:0] sleep_pressure;

  modport master (
    output tick, tired, disturb, action, vital_energy_level,
    input  sleep_in_signal, wake_up_signal, sleep_state, sleep_pressure
  );

  modport slave (
    input  tick, tired, disturb, action, vital_energy_level,
    output sleep_in_signal, wake_up_signal, sleep_state, sleep_pressure
  );
endinterface

// File: rtl/sleep_scheduler.sv
// Sleep/wake sequencer issuing single-cycle sleep_in/wake_up pulses to the action regulator.
// Optional macro SLEEP_PRESSURE_EN adds the sleep-pressure counter and its wake condition.
//
// state  | meaning
// AWAKE  | idle, waiting for tired
// DROWSY | counting undisturbed tired ticks toward sleep
// ASLEEP | counting sleep ticks, watching wake conditions
// WAKING | refractory period, waiting for regulator to leave SLEEP
module sleep_scheduler #(
  parameter int DROWSY_TICKS     = 4,
  parameter int MIN_SLEEP_TICKS  = 8,
  parameter int MAX_SLEEP_TICKS  = 32,
  parameter int REFRACTORY_TICKS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  sleep_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    AWAKE  = 2'b00,
    DROWSY = 2'b01,
    ASLEEP = 2'b10,
    WAKING = 2'b11
  } state_e;

  localparam logic [5:0] DROWSY_C = 6'(DROWSY_TICKS);
  localparam logic [5:0] MIN_C    = 6'(MIN_SLEEP_TICKS);
  localparam logic [5:0] MAX_C    = 6'(MAX_SLEEP_TICKS);
  localparam logic [5:0] REF_C    = 6'(REFRACTORY_TICKS);

  state_e     state_q;
  logic [5:0] cnt_q;
  logic       sleep_in_q;
  logic       wake_up_q;

  logic [5:0] cnt_tick_d;
  logic [5:0] cnt_wake_d;
  logic       drowsy_done;
  logic       sleep_exit;
  logic       ref_hit;
  logic       press_zero;
  logic       unused_action;

  assign unused_action = ^bus.action[7:1];

  // Wake conditions look at the count as it will be after this cycle's tick.
  assign cnt_tick_d  = (bus.tick && cnt_q != 6'd63) ? cnt_q + 6'd1 : cnt_q;
  assign cnt_wake_d  = (cnt_q == REF_C) ? cnt_q : cnt_tick_d;
  assign drowsy_done = bus.tick && ((cnt_q + 6'd1) == DROWSY_C);
  assign ref_hit     = (cnt_wake_d == REF_C);
  assign sleep_exit  = (cnt_tick_d == MAX_C) ||
                       ((cnt_tick_d >= MIN_C) &&
                        ((bus.vital_energy_level == 2'b11) || bus.disturb || press_zero));

`ifdef SLEEP_PRESSURE_EN
  logic [3:0] pressure_q;
  logic [3:0] pressure_d;

  always_comb begin
    pressure_d = pressure_q;
    if (bus.tick) begin
      case (state_q)
        AWAKE, DROWSY: if (pressure_q != 4'd15) pressure_d = pressure_q + 4'd1;
        ASLEEP:        if (pressure_q != 4'd0)  pressure_d = pressure_q - 4'd1;
        default:       pressure_d = pressure_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pressure_q <= 4'd0;
    else        pressure_q <= pressure_d;
  end

  assign press_zero         = (pressure_d == 4'd0);
  assign bus.sleep_pressure = pressure_q;
`else
  assign press_zero         = 1'b0;
  assign bus.sleep_pressure = 4'd0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= AWAKE;
      cnt_q      <= 6'd0;
      sleep_in_q <= 1'b0;
      wake_up_q  <= 1'b0;
    end else begin
      sleep_in_q <= 1'b0;
      wake_up_q  <= 1'b0;
      case (state_q)
        AWAKE: begin
          if (bus.action[0]) begin
            state_q <= ASLEEP;
            cnt_q   <= 6'd0;
          end else if (bus.tired) begin
            state_q <= DROWSY;
            cnt_q   <= 6'd0;
          end
        end
        DROWSY: begin
          if (bus.action[0]) begin
            state_q <= ASLEEP;
            cnt_q   <= 6'd0;
          end else if (!bus.tired) begin
            state_q <= AWAKE;
          end else if (bus.disturb) begin
            cnt_q <= 6'd0;
          end else if (drowsy_done) begin
            state_q    <= ASLEEP;
            cnt_q      <= 6'd0;
            sleep_in_q <= 1'b1;
          end else begin
            cnt_q <= cnt_tick_d;
          end
        end
        ASLEEP: begin
          if (sleep_exit) begin
            state_q   <= WAKING;
            cnt_q     <= 6'd0;
            wake_up_q <= 1'b1;
          end else begin
            cnt_q <= cnt_tick_d;
          end
        end
        WAKING: begin
          // Count parks at the refractory limit while the regulator still reports SLEEP.
          cnt_q <= cnt_wake_d;
          if (ref_hit) begin
            if (!bus.action[0]) state_q   <= AWAKE;
            else if (bus.tick)  wake_up_q <= 1'b1;
          end
        end
        default: state_q <= AWAKE;
      endcase
    end
  end

  assign bus.sleep_state     = state_q;
  assign bus.sleep_in_signal = sleep_in_q;
  assign bus.wake_up_signal  = wake_up_q;

endmodule
